// File: rtl/hc_sr04_responder.sv
// Sensor-side model of the HC-SR04 ranging interface: answers a valid trig
// pulse with an echo pulse whose width is taken from echo_len.
module hc_sr04_responder #(
  parameter int MIN_TRIG  = 1000,
  parameter int BURST_DLY = 20000,
  parameter int ECHO_MAX  = 3800000,
  parameter int REARM     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_trig,
  input  logic [21:0] i_echo_len,
  output logic        o_echo,
  output logic        o_busy,
  output logic        o_short_trig,
  output logic        o_echo_done,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG_HIGH = 3'd1,
    BURST     = 3'd2,
    ECHO      = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam logic [21:0] MinTrigC  = 22'(MIN_TRIG);
  localparam logic [21:0] BurstDlyC = 22'(BURST_DLY);
  localparam logic [21:0] EchoMaxC  = 22'(ECHO_MAX);
  localparam logic [21:0] RearmC    = 22'(REARM);

  state_t      r_state, w_nextState;
  logic [21:0] r_cnt, w_nextCnt;
  logic [21:0] r_len, w_nextLen;
  logic        r_trigD;
  logic        r_echo, r_shortTrig, r_echoDone;
  logic        w_nextEcho, w_nextShort, w_nextDone;
  logic        w_rise;

  // Only a fresh edge starts a measurement, so a trig stuck high never retriggers
  assign w_rise = i_trig & ~r_trigD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_trigD     <= 1'b0;
      r_echo      <= 1'b0;
      r_shortTrig <= 1'b0;
      r_echoDone  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_len       <= w_nextLen;
      r_trigD     <= i_trig;
      r_echo      <= w_nextEcho;
      r_shortTrig <= w_nextShort;
      r_echoDone  <= w_nextDone;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextLen   = r_len;
    w_nextEcho  = 1'b0;
    w_nextShort = 1'b0;
    w_nextDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && i_enable) begin
          w_nextState = TRIG_HIGH;
          w_nextCnt   = 22'd1;
        end
      end
      TRIG_HIGH: begin
        if (i_trig) begin
          if (r_cnt < MinTrigC) w_nextCnt = r_cnt + 22'd1;
        end else if (r_cnt >= MinTrigC) begin
          w_nextState = BURST;
          w_nextCnt   = 22'd1;
          // Zero or out-of-range lengths both mean "no object": use the timeout width
          w_nextLen   = (i_echo_len == 22'd0 || i_echo_len > EchoMaxC) ? EchoMaxC : i_echo_len;
        end else begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
          w_nextShort = 1'b1;
        end
      end
      BURST: begin
        if (r_cnt == BurstDlyC) begin
          w_nextState = ECHO;
          w_nextCnt   = 22'd1;
          w_nextEcho  = 1'b1;
        end else begin
          w_nextCnt = r_cnt + 22'd1;
        end
      end
      ECHO: begin
        if (r_cnt == r_len) begin
          w_nextState = HOLDOFF;
          w_nextCnt   = 22'd1;
          w_nextDone  = 1'b1;
        end else begin
          w_nextCnt  = r_cnt + 22'd1;
          w_nextEcho = 1'b1;
        end
      end
      HOLDOFF: begin
        if (r_cnt == RearmC) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 22'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign o_echo       = r_echo;
  assign o_short_trig = r_shortTrig;
  assign o_echo_done  = r_echoDone;
  assign o_busy       = (r_state != IDLE);
  assign o_state      = r_state;

endmodule
